multi_core_irq_router: RTL and testbench

//  Upstream interrupt stage of the multi-core system: gathers NUM_SOURCES device lines and drives the per-core

---
 rtl/riscv_core_pkg.sv | 24 ++
 rtl/mc_irq_prio_select.sv | 26 ++
 rtl/multi_core_irq_router.sv | 192 +++++++++++++++++++
 tb/tb_multi_core_irq_router.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_pkg.sv
// Shared types and config-space layout for the interrupt router.
package riscv_core_pkg;

  localparam int unsigned IRQ_ID_W   = 5;
  localparam int unsigned IRQ_PRIO_W = 3;

  typedef logic [IRQ_ID_W-1:0]   irq_id_t;
  typedef logic [IRQ_PRIO_W-1:0] irq_prio_t;

  localparam logic [7:0] IRQ_CFG_PRIO_BASE = 8'h00;
  localparam logic [7:0] IRQ_CFG_EN_BASE   = 8'h40;
  localparam logic [7:0] IRQ_CFG_THR_BASE  = 8'h60;

  typedef enum logic [1:0] {CfgNone, CfgPrio, CfgEn, CfgThr} cfg_sel_e;

  // Region decode of a config word index; range checks on the offset happen at the use site.
  function automatic cfg_sel_e cfg_decode(input logic [7:0] addr);
    if (addr[7:6] == IRQ_CFG_PRIO_BASE[7:6]) return CfgPrio;
    if (addr[7:5] == IRQ_CFG_EN_BASE[7:5])   return CfgEn;
    if (addr[7:5] == IRQ_CFG_THR_BASE[7:5])  return CfgThr;
    return CfgNone;
  endfunction

endpackage

// File: rtl/mc_irq_prio_select.sv
// Combinational picker: highest-priority eligible source, ties resolved to the lowest ID.
module mc_irq_prio_select #(
  parameter int unsigned NUM_SOURCES = 32,
  parameter int unsigned PRIO_W      = 3,
  parameter int unsigned ID_W        = 5
) (
  input  logic [NUM_SOURCES-1:0]        eligible_i,
  input  logic [NUM_SOURCES*PRIO_W-1:0] prio_i,
  output logic [ID_W-1:0]               id_o
);

  logic [PRIO_W-1:0] best_prio;

  // Scan downwards with >= so that equal priorities settle on the lowest ID.
  always_comb begin
    best_prio = '0;
    id_o      = '0;
    for (int s = NUM_SOURCES - 1; s >= 0; s--) begin
      if (eligible_i[s] && (prio_i[s*PRIO_W +: PRIO_W] >= best_prio)) begin
        best_prio = prio_i[s*PRIO_W +: PRIO_W];
        id_o      = ID_W'(s);
      end
    end
  end

endmodule

// File: rtl/multi_core_irq_router.sv
// PLIC-lite interrupt router: gateway, config registers, claim/complete and per-core outputs.
// Optional feature macro MC_IRQ_EDGE_EN selects rising-edge gateways with a 1-deep edge latch.
module multi_core_irq_router
  import riscv_core_pkg::*;
#(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned NUM_SOURCES = 32,
  parameter int unsigned PRIO_W      = 3,
  localparam int unsigned ID_W       = $clog2(NUM_SOURCES)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SOURCES-1:0]    irq_src_i,
  output logic [NUM_CORES-1:0]      irq_o,
  input  logic [NUM_CORES-1:0]      claim_i,
  output logic [NUM_CORES*ID_W-1:0] claim_id_o,
  input  logic [NUM_CORES-1:0]      complete_i,
  input  logic [NUM_CORES*ID_W-1:0] complete_id_i,
  input  logic                      cfg_we_i,
  input  logic                      cfg_re_i,
  input  logic [7:0]                cfg_addr_i,
  input  logic [31:0]               cfg_wdata_i,
  output logic [31:0]               cfg_rdata_o
);

  logic [NUM_SOURCES-1:0]    pending_q, pending_d, in_flight_q, in_flight_d;
  logic [NUM_SOURCES-1:0]    claim_clr, cmpl_clr, gw_set, avail;
  logic [PRIO_W-1:0]         prio_q [NUM_SOURCES];
  logic [PRIO_W-1:0]         prio_d [NUM_SOURCES];
  logic [NUM_SOURCES-1:0]    en_q [NUM_CORES];
  logic [NUM_SOURCES-1:0]    en_d [NUM_CORES];
  logic [PRIO_W-1:0]         thr_q [NUM_CORES];
  logic [PRIO_W-1:0]         thr_d [NUM_CORES];
  logic [NUM_CORES-1:0]      irq_q, irq_d;
  logic [NUM_CORES*ID_W-1:0] claim_id_q, best_flat;
  logic [31:0]               rdata_q, rdata_d;
  logic [NUM_SOURCES*PRIO_W-1:0] prio_flat;
  logic [7:0]                prio_off, en_off, thr_off;
  cfg_sel_e                  cfg_sel;

`ifdef MC_IRQ_EDGE_EN
  logic [NUM_SOURCES-1:0] src_prev_q, edge_latch_q, edge_latch_d, src_edge, idle;
`endif

  // Claim/complete resolution and gateway next-state.
  always_comb begin
    claim_clr = '0;
    cmpl_clr  = '0;
    // Earlier cores mark the source first, so later claims of the same ID see nothing extra.
    for (int c = 0; c < NUM_CORES; c++) begin
      for (int s = 1; s < NUM_SOURCES; s++) begin
        if (claim_i[c] && (claim_id_q[c*ID_W +: ID_W] == ID_W'(s)) && pending_q[s]) begin
          claim_clr[s] = 1'b1;
        end
        if (complete_i[c] && (complete_id_i[c*ID_W +: ID_W] == ID_W'(s)) && in_flight_q[s]) begin
          cmpl_clr[s] = 1'b1;
        end
      end
    end
`ifdef MC_IRQ_EDGE_EN
    src_edge     = irq_src_i & ~src_prev_q;
    idle         = ~in_flight_q & ~pending_q;
    gw_set       = (src_edge | edge_latch_q) & idle;
    edge_latch_d = (edge_latch_q & ~idle) | (src_edge & ~idle);
    edge_latch_d[0] = 1'b0;
`else
    gw_set = irq_src_i & ~in_flight_q & ~pending_q;
`endif
    gw_set[0]   = 1'b0;
    pending_d   = (pending_q & ~claim_clr) | gw_set;
    in_flight_d = (in_flight_q & ~cmpl_clr) | claim_clr;
  end

  // Sources taken this cycle are withheld from arbitration so the claimer's line drops at once.
  assign avail = pending_q & ~claim_clr;

  // Flatten priorities for the per-core pickers.
  always_comb begin
    prio_flat = '0;
    for (int s = 0; s < NUM_SOURCES; s++) begin
      prio_flat[s*PRIO_W +: PRIO_W] = prio_q[s];
    end
  end

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    logic [NUM_SOURCES-1:0] elig;

    // Eligibility: pending, enabled for this core and strictly above its threshold.
    always_comb begin
      elig = '0;
      for (int s = 0; s < NUM_SOURCES; s++) begin
        elig[s] = avail[s] & en_q[c][s] & (prio_q[s] > thr_q[c]);
      end
    end

    mc_irq_prio_select #(
      .NUM_SOURCES(NUM_SOURCES),
      .PRIO_W     (PRIO_W),
      .ID_W       (ID_W)
    ) u_sel (
      .eligible_i(elig),
      .prio_i    (prio_flat),
      .id_o      (best_flat[c*ID_W +: ID_W])
    );

    assign irq_d[c] = |best_flat[c*ID_W +: ID_W];
  end

  assign prio_off = cfg_addr_i - IRQ_CFG_PRIO_BASE;
  assign en_off   = cfg_addr_i - IRQ_CFG_EN_BASE;
  assign thr_off  = cfg_addr_i - IRQ_CFG_THR_BASE;
  assign cfg_sel  = cfg_decode(cfg_addr_i);

  // Config read (old values) and write; source 0 priority stays hard-wired to 0.
  always_comb begin
    prio_d  = prio_q;
    en_d    = en_q;
    thr_d   = thr_q;
    rdata_d = '0;
    if (cfg_re_i) begin
      unique case (cfg_sel)
        CfgPrio: for (int s = 0; s < NUM_SOURCES; s++) begin
          if (prio_off == 8'(s)) rdata_d = 32'(prio_q[s]);
        end
        CfgEn: for (int c = 0; c < NUM_CORES; c++) begin
          if (en_off == 8'(c)) rdata_d = 32'(en_q[c]);
        end
        CfgThr: for (int c = 0; c < NUM_CORES; c++) begin
          if (thr_off == 8'(c)) rdata_d = 32'(thr_q[c]);
        end
        default: ;
      endcase
    end
    if (cfg_we_i) begin
      unique case (cfg_sel)
        CfgPrio: for (int s = 1; s < NUM_SOURCES; s++) begin
          if (prio_off == 8'(s)) prio_d[s] = cfg_wdata_i[PRIO_W-1:0];
        end
        CfgEn: for (int c = 0; c < NUM_CORES; c++) begin
          if (en_off == 8'(c)) en_d[c] = {cfg_wdata_i[NUM_SOURCES-1:1], 1'b0};
        end
        CfgThr: for (int c = 0; c < NUM_CORES; c++) begin
          if (thr_off == 8'(c)) thr_d[c] = cfg_wdata_i[PRIO_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q   <= '0;
      in_flight_q <= '0;
      irq_q       <= '0;
      claim_id_q  <= '0;
      rdata_q     <= '0;
      for (int s = 0; s < NUM_SOURCES; s++) prio_q[s] <= '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        en_q[c]  <= '0;
        thr_q[c] <= '0;
      end
    end else begin
      pending_q   <= pending_d;
      in_flight_q <= in_flight_d;
      irq_q       <= irq_d;
      claim_id_q  <= best_flat;
      rdata_q     <= rdata_d;
      prio_q      <= prio_d;
      en_q        <= en_d;
      thr_q       <= thr_d;
    end
  end

`ifdef MC_IRQ_EDGE_EN
  // Edge-detect history and the 1-deep latch for edges seen while busy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_prev_q   <= '0;
      edge_latch_q <= '0;
    end else begin
      src_prev_q   <= irq_src_i;
      edge_latch_q <= edge_latch_d;
    end
  end
`endif

  assign irq_o       = irq_q;
  assign claim_id_o  = claim_id_q;
  assign cfg_rdata_o = rdata_q;

endmodule

// File: tb/tb_multi_core_irq_router.sv
// Self-checking bench for multi_core_irq_router: directed scenarios plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_multi_core_irq_router;

  localparam int NC = 4;
  localparam int NS = 32;
  localparam int IW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     src;
  logic [NC-1:0]     irq, claim, complete;
  logic [NC*IW-1:0]  claim_id, complete_id;
  logic              we, re;
  logic [7:0]        addr;
  logic [31:0]       wdata, rdata;

  multi_core_irq_router #(
    .NUM_CORES  (NC),
    .NUM_SOURCES(NS),
    .PRIO_W     (3)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .irq_src_i    (src),
    .irq_o        (irq),
    .claim_i      (claim),
    .claim_id_o   (claim_id),
    .complete_i   (complete),
    .complete_id_i(complete_id),
    .cfg_we_i     (we),
    .cfg_re_i     (re),
    .cfg_addr_i   (addr),
    .cfg_wdata_i  (wdata),
    .cfg_rdata_o  (rdata)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          m_prio [NS];
  bit [NS-1:0] m_en   [NC];
  int          m_thr  [NC];
  bit          m_pend [NS];
  bit          m_infl [NS];
  bit          m_prev [NS];
  bit          m_latch[NS];
  bit [NC-1:0] m_irq;
  int          m_cid  [NC];
  bit [31:0]   m_rdata;

  int checks = 0;
  int failures = 0;
  int order[3] = '{12, 3, 9};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] cid(input int c);
    return 32'(claim_id[c*IW +: IW]);
  endfunction

  // One clock of the reference: claims, completions, gateway, arbitration, config.
  task automatic model_step();
    bit taken[NS];
    bit cmpl[NS];
    bit np[NS], ni[NS], nl[NS];
    int id, best, bp;
    if (rst) begin
      for (int s = 0; s < NS; s++) begin
        m_prio[s] = 0; m_pend[s] = 0; m_infl[s] = 0; m_prev[s] = 0; m_latch[s] = 0;
      end
      for (int c = 0; c < NC; c++) begin
        m_en[c] = '0; m_thr[c] = 0; m_cid[c] = 0;
      end
      m_irq = '0;
      m_rdata = '0;
      return;
    end
    for (int s = 0; s < NS; s++) begin
      taken[s] = 0; cmpl[s] = 0;
    end
    for (int c = 0; c < NC; c++) begin
      if (claim[c] && m_cid[c] != 0 && m_pend[m_cid[c]]) taken[m_cid[c]] = 1;
      id = int'(complete_id[c*IW +: IW]);
      if (complete[c] && id != 0 && m_infl[id]) cmpl[id] = 1;
    end
    for (int s = 0; s < NS; s++) begin
      bit setp, busy, edg;
      busy = m_pend[s] || m_infl[s];
      nl[s] = m_latch[s];
`ifdef MC_IRQ_EDGE_EN
      edg  = src[s] && !m_prev[s];
      setp = !busy && (edg || m_latch[s]);
      if (!busy) nl[s] = 0;
      else if (edg) nl[s] = 1;
`else
      edg  = 0;
      setp = src[s] && !busy;
`endif
      if (s == 0) begin
        setp = 0; nl[s] = 0;
      end
      np[s] = (m_pend[s] && !taken[s]) || setp;
      ni[s] = (m_infl[s] && !cmpl[s]) || taken[s];
    end
    for (int c = 0; c < NC; c++) begin
      best = 0; bp = 0;
      for (int s = 1; s < NS; s++) begin
        if (m_pend[s] && !taken[s] && m_en[c][s] && m_prio[s] > m_thr[c] && m_prio[s] > bp) begin
          bp = m_prio[s]; best = s;
        end
      end
      m_cid[c] = best;
      m_irq[c] = (best != 0);
    end
    m_rdata = '0;
    if (re) begin
      if (addr < NS) m_rdata = 32'(m_prio[addr]);
      else if (addr >= 8'h40 && addr < 8'h40 + NC) m_rdata = 32'(m_en[addr - 8'h40]);
      else if (addr >= 8'h60 && addr < 8'h60 + NC) m_rdata = 32'(m_thr[addr - 8'h60]);
    end
    if (we) begin
      if (addr >= 1 && addr < NS) m_prio[addr] = int'(wdata % 8);
      else if (addr >= 8'h40 && addr < 8'h40 + NC) m_en[addr - 8'h40] = wdata & 32'hFFFF_FFFE;
      else if (addr >= 8'h60 && addr < 8'h60 + NC) m_thr[addr - 8'h60] = int'(wdata % 8);
    end
    for (int s = 0; s < NS; s++) begin
      m_pend[s] = np[s]; m_infl[s] = ni[s]; m_latch[s] = nl[s]; m_prev[s] = src[s];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("model_irq", 32'(irq), 32'(m_irq));
    for (int c = 0; c < NC; c++) check_eq($sformatf("model_cid%0d", c), cid(c), 32'(m_cid[c]));
    check_eq("model_rdata", rdata, m_rdata);
    claim = '0; complete = '0; we = 0; re = 0;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    we = 1; addr = a; wdata = d;
    tick();
  endtask

  task automatic do_reset();
    rst = 1; src = '0;
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1; src = '1; claim = '0; complete = '0; complete_id = '0;
    we = 0; re = 0; addr = '0; wdata = '0;

    // Reset held with all sources high
    repeat (2) begin
      re = 1;
      tick();
      check_eq("rst_irq", 32'(irq), 0);
      check_eq("rst_cid", 32'(claim_id), 0);
      check_eq("rst_rdata", rdata, 0);
    end
    do_reset();

    // Basic path and read-during-write
    we = 1; re = 1; addr = 8'h05; wdata = 3;
    tick();
    check_eq("rd_old", rdata, 0);
    re = 1; addr = 8'h05;
    tick();
    check_eq("rd_new", rdata, 3);
    cfg_write(8'h40, 32'h20);
    src[5] = 1;
    tick();
    check_eq("basic_t1", 32'(irq[0]), 0);
    tick();
    check_eq("basic_t2", 32'(irq[0]), 1);
    check_eq("basic_id", cid(0), 5);
    claim[0] = 1;
    tick();
    check_eq("basic_claim", 32'(irq[0]), 0);
    src[5] = 0; complete[0] = 1; complete_id[0 +: IW] = 5;
    tick();

    // Priority and tie ordering on core 1
    do_reset();
    cfg_write(8'h03, 2);
    cfg_write(8'h09, 2);
    cfg_write(8'h0C, 4);
    cfg_write(8'h41, (1 << 3) | (1 << 9) | (1 << 12));
    src[3] = 1; src[9] = 1; src[12] = 1;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("order_id", cid(1), 32'(order[i]));
      claim[1] = 1;
      tick();
    end
    check_eq("order_done", cid(1), 0);
    cfg_write(8'h61, 4);
    for (int i = 0; i < 3; i++) begin
      complete[1] = 1; complete_id[IW +: IW] = IW'(order[i]);
      tick();
    end
    repeat (3) tick();
    check_eq("thr_mask", 32'(irq[1]), 0);
    cfg_write(8'h61, 3);
    tick();
    check_eq("thr_lower", cid(1), 12);

    // Race on source 7 and completion behaviour
    do_reset();
    cfg_write(8'h07, 1);
    cfg_write(8'h40, 1 << 7);
    cfg_write(8'h42, 1 << 7);
    src[7] = 1;
    tick(); tick();
    check_eq("race_c0", cid(0), 7);
    check_eq("race_c2", cid(2), 7);
    claim = 4'b0101;
    tick();
    check_eq("race_c2_after", cid(2), 0);
    check_eq("race_irq2", 32'(irq[2]), 0);
    complete[0] = 1; complete_id[0 +: IW] = 0;
    complete[2] = 1; complete_id[2*IW +: IW] = 4;
    tick(); tick(); tick();
    check_eq("bogus_cmpl", 32'(irq[0]), 0);
    complete[0] = 1; complete_id[0 +: IW] = 7;
    tick();
    check_eq("cmpl_t1", 32'(irq[0]), 0);
    tick();
    check_eq("cmpl_t2", 32'(irq[0]), 0);
    tick();
    check_eq("cmpl_t3", 32'(irq[0]), 1);
    check_eq("cmpl_id", cid(0), 7);

    // Pulses while in flight
    do_reset();
    cfg_write(8'h06, 2);
    cfg_write(8'h43, 1 << 6);
    src[6] = 1;
    tick();
    src[6] = 0;
    tick();
    check_eq("pulse_irq", 32'(irq[3]), 1);
    check_eq("pulse_id", cid(3), 6);
    claim[3] = 1;
    tick();
    src[6] = 1; tick(); src[6] = 0; tick(); src[6] = 1; tick(); src[6] = 0; tick();
    complete[3] = 1; complete_id[3*IW +: IW] = 6;
    tick(); tick(); tick(); tick();
`ifdef MC_IRQ_EDGE_EN
    check_eq("edge_once", 32'(irq[3]), 1);
    claim[3] = 1;
    tick();
    complete[3] = 1; complete_id[3*IW +: IW] = 6;
    tick();
    repeat (4) tick();
    check_eq("edge_merged", 32'(irq[3]), 0);
`else
    check_eq("level_pulse_lost", 32'(irq[3]), 0);
`endif

    // Randomized traffic
    do_reset();
    for (int s = 1; s < NS; s++) cfg_write(8'(s), $urandom_range(0, 7));
    for (int c = 0; c < NC; c++) begin
      cfg_write(8'(8'h40 + c), $urandom);
      cfg_write(8'(8'h60 + c), $urandom_range(0, 2));
    end
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) src = src ^ (32'h1 << $urandom_range(0, 31));
      for (int c = 0; c < NC; c++) begin
        claim[c] = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 3) == 0) begin
          int id;
          id = $urandom_range(0, NS - 1);
          if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < NS; k++) begin
              if (m_infl[(id + k) % NS]) begin
                id = (id + k) % NS;
                break;
              end
            end
          end
          complete[c] = 1;
          complete_id[c*IW +: IW] = IW'(id);
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: addr = 8'($urandom_range(0, 8'h3F));
          1: addr = 8'($urandom_range(8'h40, 8'h47));
          2: addr = 8'($urandom_range(8'h60, 8'h67));
          default: addr = 8'($urandom_range(8'h80, 8'hFF));
        endcase
        wdata = (addr[7:5] == 3'b011) ? ($urandom & 32'h3) : $urandom;
        we = ($urandom_range(0, 1) == 1);
        re = ($urandom_range(0, 1) == 1);
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
      rst = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
